operand_digit_serializer: RTL and testbench
===========================================

OPERAND_DIGIT_SERIALIZER -- requirements
Module: operand_digit_serializer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 1024, meaning the operand width in bits (even, >= 4).
REQ-002 The module SHALL have parameter DIGIT_W, default 2, meaning the bits emitted per digit (radix-4); WIDTH SHALL be a multiple of DIGIT_W.
REQ-003 Port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port load, input, 1 bit: request to capture in_number.
REQ-006 Port in_number, input, WIDTH bits: operand to serialize.
REQ-007 Port digit_out, output, DIGIT_W bits: current least-significant digit.
REQ-008 Port digit_valid, output, 1 bit: digit_out is valid.
REQ-009 Port digit_ready, input, 1 bit: consumer accepts digit_out.
REQ-010 Port digit_last, output, 1 bit: digit_out is the final (most-significant) digit.
REQ-011 Port busy, output, 1 bit: serialization is in progress.
REQ-012 Port done, output, 1 bit: one-cycle pulse after the final digit is accepted.

Function
REQ-013 The FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-014 IDLE: load=1 SHALL capture in_number into the operand register, clear the digit counter, and enter SHIFT on the next cycle.
REQ-015 SHIFT: digit_valid=1, busy=1, and digit_out = operand_reg[DIGIT_W-1:0] (registered, with no combinational path from inputs).
REQ-016 A handshake SHALL occur when digit_valid && digit_ready; on a handshake operand_reg SHALL shift right by DIGIT_W with zero fill and the counter SHALL increment.
REQ-017 Without a handshake, digit_out, digit_last and the counter SHALL hold their values.
REQ-018 digit_last SHALL be 1 only in SHIFT when the counter equals WIDTH/DIGIT_W-1.
REQ-019 A handshake with digit_last=1 SHALL move the FSM to DONE; no further shift is required.
REQ-020 DONE SHALL hold done=1, busy=0 and digit_valid=0 for exactly one cycle, then return to IDLE.
REQ-021 load asserted in SHIFT or DONE SHALL be ignored, leaving the operand and the counter unchanged.
REQ-022 load asserted in the same cycle as done SHALL be ignored; a new load is accepted from IDLE only.
REQ-023 The counter SHALL be $clog2(WIDTH/DIGIT_W) bits wide, SHALL never wrap within one operand, and SHALL reach its terminal count only via REQ-019.
REQ-024 Latency: the first digit is valid 1 cycle after load. With digit_ready held at 1, done pulses WIDTH/DIGIT_W+1 cycles after load (513 cycles for the defaults).
REQ-025 Digits SHALL be emitted LSB-first: digit k = in_number[DIGIT_W*k+DIGIT_W-1 : DIGIT_W*k].

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE and clear operand_reg, the counter, digit_out, digit_valid, digit_last, busy and done to 0.
REQ-027 rst SHALL take priority over load and any handshake in the same cycle.
REQ-028 rst asserted mid-SHIFT SHALL abort the operation without a done pulse; the next load after reset deasserts SHALL start cleanly.

Structure
REQ-029 The state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the derived constant NUM_DIGITS=WIDTH/DIGIT_W SHALL live in the shared Montgomery package/header.
REQ-030 The design SHALL be a single module with no sub-module; the counter and the shifter SHALL be inline.

Verification
REQ-031 Streaming: WIDTH=1024, in_number=...0000_001B (0x1B), digit_ready=1 -> digits 3,2,1,0,0,... (512 total); digit_last on digit 511; done exactly 513 cycles after load.
REQ-032 Backpressure: WIDTH=8, in_number=8'hE4, digit_ready toggling 1,0,1,0 -> digits 0,1,2,3 in order; each digit is held stable while digit_ready=0; done follows the 4th accept.
REQ-033 Ignored load: WIDTH=8, load 8'hFF, then mid-stream load 8'h00 -> all four digits are 3; counter is undisturbed.
REQ-034 Reset mid-operation: WIDTH=8, load 8'hE4, rst after 2 accepts -> all outputs are 0 next cycle and no done pulse; a fresh load of 8'h1B yields digits 3,2,1,0.
REQ-035 Done/load collision: WIDTH=8, load asserted in the done cycle -> the load is ignored and the FSM stays in IDLE; load one cycle later is accepted.

Source files
------------

// File: rtl/operand_digit_serializer_pkg.sv
// Shared definitions for the operand digit serializer.
// State encoding and digit-count helpers.
package operand_digit_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_e;

  localparam int unsigned DEF_WIDTH   = 1024;
  localparam int unsigned DEF_DIGIT_W = 2;
  localparam int unsigned NUM_DIGITS  =
    DEF_WIDTH / DEF_DIGIT_W;

  function automatic int unsigned num_digits(
    input int unsigned width,
    input int unsigned digit_w
  );
    return width / digit_w;
  endfunction

  function automatic int unsigned cnt_bits(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/operand_digit_serializer.sv
// Operand digit serializer: emits a wide operand
// LSB-first, DIGIT_W bits per valid/ready handshake.
module operand_digit_serializer
  import operand_digit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned DIGIT_W = DEF_DIGIT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   in_number,
  output logic [DIGIT_W-1:0] digit_out,
  output logic               digit_valid,
  input  logic               digit_ready,
  output logic               digit_last,
  output logic               busy,
  output logic               done
);

  localparam int unsigned ND = num_digits(WIDTH, DIGIT_W);
  localparam int unsigned CW = cnt_bits(ND);
  localparam logic [CW-1:0] LAST_CNT = CW'(ND - 1);

  ser_state_e        state_q;
  ser_state_e        state_d;
  logic [WIDTH-1:0]  operand_q;
  logic [CW-1:0]     cnt_q;
  logic              hs;
  logic              is_last;

  assign hs      = (state_q == SHIFT) && digit_ready;
  assign is_last = (cnt_q == LAST_CNT);

  // Next-state: load only from IDLE, finish on last accept.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load) state_d = SHIFT;
      SHIFT:   if (hs && is_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand shifter and digit counter; counter parks
  // on the terminal count so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      operand_q <= '0;
      cnt_q     <= '0;
    end else if (state_q == IDLE && load) begin
      operand_q <= in_number;
      cnt_q     <= '0;
    end else if (hs) begin
      operand_q <= operand_q >> DIGIT_W;
      if (!is_last) cnt_q <= cnt_q + CW'(1);
    end
  end

  assign digit_out   = operand_q[DIGIT_W-1:0];
  assign digit_valid = (state_q == SHIFT);
  assign busy        = (state_q == SHIFT);
  assign done        = (state_q == DONE);
  assign digit_last  = (state_q == SHIFT) && is_last;

endmodule

// File: tb/tb_operand_digit_serializer.sv
// Bench for operand_digit_serializer: 1024-bit stream
// plus a WIDTH=8 vector table for multi-cycle corners.
module tb_operand_digit_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Small instance, WIDTH=8
  logic       rst_s, load_s, rdy_s;
  logic [7:0] din_s;
  logic [1:0] dig_s;
  logic       v_s, l_s, b_s, dn_s;

  operand_digit_serializer #(
    .WIDTH(8),
    .DIGIT_W(2)
  ) dut_s (
    .clk(clk),
    .rst(rst_s),
    .load(load_s),
    .in_number(din_s),
    .digit_out(dig_s),
    .digit_valid(v_s),
    .digit_ready(rdy_s),
    .digit_last(l_s),
    .busy(b_s),
    .done(dn_s)
  );

  // Default instance, WIDTH=1024
  logic          rst_b, load_b, rdy_b;
  logic [1023:0] din_b;
  logic [1:0]    dig_b;
  logic          v_b, l_b, b_b, dn_b;

  operand_digit_serializer dut_b (
    .clk(clk),
    .rst(rst_b),
    .load(load_b),
    .in_number(din_b),
    .digit_out(dig_b),
    .digit_valid(v_b),
    .digit_ready(rdy_b),
    .digit_last(l_b),
    .busy(b_b),
    .done(dn_b)
  );

  typedef struct {
    logic       rst;
    logic       load;
    logic [7:0] din;
    logic       rdy;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(
    input logic       rst,
    input logic       load,
    input logic [7:0] din,
    input logic       rdy,
    input logic       v,
    input logic [1:0] d,
    input logic       l,
    input logic       b,
    input logic       dn
  );
    vec_t e;
    e.rst  = rst;
    e.load = load;
    e.din  = din;
    e.rdy  = rdy;
    e.exp  = {v, d, l, b, dn};
    tbl.push_back(e);
  endtask

  task automatic chk(
    input string name,
    input int    got,
    input int    want
  );
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h",
               name, got, want);
    end
  endtask

  initial begin
    int         cyc;
    int         k;
    bit         seen_done;
    logic [5:0] got;

    rst_s  = 1'b1; load_s = 1'b0;
    din_s  = '0;   rdy_s  = 1'b0;
    rst_b  = 1'b1; load_b = 1'b0;
    din_b  = '0;   rdy_b  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_big",
        int'({v_b, dig_b, l_b, b_b, dn_b}), 0);

    // 1024-bit stream of 0x1B, ready held high
    rst_b  = 1'b0;
    din_b  = 1024'h1B;
    load_b = 1'b1;
    rdy_b  = 1'b1;
    @(posedge clk);
    #1;
    load_b    = 1'b0;
    din_b     = '0;
    cyc       = 1;
    k         = 0;
    seen_done = 1'b0;
    while (cyc < 600 && !seen_done) begin
      if (dn_b) begin
        seen_done = 1'b1;
      end else begin
        if (v_b) begin
          if (dig_b !== ((k < 4) ? 2'(3 - k) : 2'd0)) begin
            checks++;
            failures++;
            $display("FAIL stream_digit%0d got=%0d", k, dig_b);
          end
          if (l_b !== (k == 511)) begin
            checks++;
            failures++;
            $display("FAIL stream_last%0d got=%0b", k, l_b);
          end
          k++;
        end
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    chk("stream_first_digits_seen", k, 512);
    chk("stream_done_seen", int'(seen_done), 1);
    chk("stream_done_latency", cyc, 513);
    @(posedge clk);
    #1;
    chk("stream_idle_after",
        int'({v_b, l_b, b_b, dn_b}), 0);

    // WIDTH=8 vectors: {rst,load,din,rdy} -> v,d,l,b,dn
    add(1, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    // backpressure on E4 -> 0,1,2,3
    add(0, 1, 8'hE4, 0, 1, 0, 0, 1, 0);
    add(0, 0, 8'h00, 1, 1, 1, 0, 1, 0);
    add(0, 0, 8'h00, 0, 1, 1, 0, 1, 0);
    add(0, 0, 8'h00, 1, 1, 2, 0, 1, 0);
    add(0, 0, 8'h00, 0, 1, 2, 0, 1, 0);
    add(0, 0, 8'h00, 1, 1, 3, 1, 1, 0);
    add(0, 0, 8'h00, 0, 1, 3, 1, 1, 0);
    add(0, 0, 8'h00, 1, 0, 0, 0, 0, 1);
    // load during done is dropped
    add(0, 1, 8'h1B, 1, 0, 0, 0, 0, 0);
    // load one cycle later is taken; mid-stream loads dropped
    add(0, 1, 8'hFF, 1, 1, 3, 0, 1, 0);
    add(0, 1, 8'h00, 1, 1, 3, 0, 1, 0);
    add(0, 1, 8'h00, 1, 1, 3, 0, 1, 0);
    add(0, 0, 8'h00, 1, 1, 3, 1, 1, 0);
    add(0, 1, 8'h00, 1, 0, 0, 0, 0, 1);
    add(0, 0, 8'h00, 1, 0, 0, 0, 0, 0);
    // reset after two accepts, beats load and handshake
    add(0, 1, 8'hE4, 0, 1, 0, 0, 1, 0);
    add(0, 0, 8'h00, 1, 1, 1, 0, 1, 0);
    add(0, 0, 8'h00, 1, 1, 2, 0, 1, 0);
    add(1, 1, 8'hFF, 1, 0, 0, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 0, 0, 0);
    add(0, 1, 8'h1B, 1, 1, 3, 0, 1, 0);
    add(0, 0, 8'h00, 1, 1, 2, 0, 1, 0);
    add(0, 0, 8'h00, 1, 1, 1, 0, 1, 0);
    add(0, 0, 8'h00, 1, 1, 0, 1, 1, 0);
    add(0, 0, 8'h00, 1, 0, 0, 0, 0, 1);
    add(0, 0, 8'h00, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst_s  = tbl[i].rst;
      load_s = tbl[i].load;
      din_s  = tbl[i].din;
      rdy_s  = tbl[i].rdy;
      @(posedge clk);
      #1;
      got = {v_s, dig_s, l_s, b_s, dn_s};
      checks++;
      if (got !== tbl[i].exp) begin
        failures++;
        $display("FAIL row%0d v_d_l_b_dn got=%b want=%b",
                 i, got, tbl[i].exp);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
